// File: rtl/ssram_arbiter_pkg.sv
// Shared definitions for the SSRAM arbiter: idle pin levels, the read-tag layout
// and the default read latency of the pipelined SSRAM.
package ssram_arbiter_pkg;

    localparam int DEFAULT_READ_LATENCY = 2;

    localparam logic       IDLE_ADSC_N = 1'b1;
    localparam logic       IDLE_WE_N   = 1'b1;
    localparam logic       IDLE_OE_N   = 1'b1;
    localparam logic       IDLE_DQ_OE  = 1'b0;
    localparam logic [3:0] IDLE_BE_N   = 4'hF;

    // One read-tag stage: valid marks an in-flight read, owner is the port (1 = m1).
    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    localparam tag_t TAG_EMPTY = '{valid: 1'b0, owner: 1'b0};

endpackage

// File: rtl/ssram_rr_arbiter.sv
// Two-way round-robin arbiter; a winner that is not eligible blocks the grant
// rather than letting the other port through.
module ssram_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] elig_i,
    output logic [1:0] grant_o
);
    import ssram_arbiter_pkg::*;

    logic last_q;
    logic last_d;
    logic pick_s;

    // Winner selection and pointer next-state
    always_comb begin
        pick_s  = 1'b0;
        grant_o = 2'b00;
        last_d  = last_q;
        if (&req_i) begin
            pick_s = ~last_q;
        end else begin
            pick_s = ~req_i[0];
        end
        if (req_i[pick_s] && elig_i[pick_s]) begin
            grant_o[pick_s] = 1'b1;
            last_d          = pick_s;
        end else begin
            grant_o = 2'b00;
            last_d  = last_q;
        end
    end

    // Last-winner pointer; resets as if m1 won last so m0 is preferred first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ssram_arbiter.sv
// Shares one pipelined ADSC-strobed SSRAM between two requesters: arbitration,
// registered pin drive, read-tag pipeline and per-port read-return demux.
module ssram_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = ssram_arbiter_pkg::DEFAULT_READ_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_ack,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_ack,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ssram_addr,
    output logic [3:0]        ssram_be_n,
    output logic              ssram_adsc_n,
    output logic              ssram_we_n,
    output logic              ssram_oe_n,
    output logic [DATA_W-1:0] ssram_dq_out,
    output logic              ssram_dq_oe,
    input  logic [DATA_W-1:0] ssram_dq_in
);
    import ssram_arbiter_pkg::*;

    logic [1:0] grant_s;
    logic       busy_s, early_s, sel_m1_s, sel_we_s, rd_grant_s;

    tag_t [READ_LATENCY:0] tag_q, tag_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              adsc_n_q, adsc_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    // Pipeline occupancy: busy covers every stage, early excludes the sample stage
    always_comb begin
        busy_s  = 1'b0;
        early_s = 1'b0;
        for (int k = 0; k <= READ_LATENCY; k++) begin
            busy_s = busy_s | tag_q[k].valid;
        end
        for (int k = 0; k < READ_LATENCY; k++) begin
            early_s = early_s | tag_q[k].valid;
        end
    end

    ssram_rr_arbiter u_rr (
        .clk    (clk),
        .reset  (reset),
        .req_i  ({m1_req, m0_req}),
        .elig_i ({~(m1_we & busy_s), ~(m0_we & busy_s)}),
        .grant_o(grant_s)
    );

    assign m0_ack     = grant_s[0];
    assign m1_ack     = grant_s[1];
    assign sel_m1_s   = grant_s[1];
    assign sel_we_s   = sel_m1_s ? m1_we : m0_we;
    assign rd_grant_s = (|grant_s) & ~sel_we_s;

    // Pin, tag and return next-state
    always_comb begin
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        be_n_d   = IDLE_BE_N;
        adsc_n_d = IDLE_ADSC_N;
        we_n_d   = IDLE_WE_N;
        dq_oe_d  = IDLE_DQ_OE;
        if (|grant_s) begin
            adsc_n_d = 1'b0;
            addr_d   = sel_m1_s ? m1_addr : m0_addr;
            be_n_d   = sel_m1_s ? ~m1_be : ~m0_be;
            we_n_d   = ~sel_we_s;
            if (sel_we_s) begin
                dq_out_d = sel_m1_s ? m1_wdata : m0_wdata;
                dq_oe_d  = 1'b1;
            end else begin
                dq_out_d = dq_out_q;
                dq_oe_d  = IDLE_DQ_OE;
            end
        end else begin
            adsc_n_d = IDLE_ADSC_N;
        end
        // Bus is turned toward us whenever any read will sit in stages 0..RL next cycle
        oe_n_d = ~(rd_grant_s | early_s);

        tag_d[0] = '{valid: rd_grant_s, owner: sel_m1_s};
        for (int k = 1; k <= READ_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        m0_rvalid_d = tag_q[READ_LATENCY].valid & ~tag_q[READ_LATENCY].owner;
        m1_rvalid_d = tag_q[READ_LATENCY].valid &  tag_q[READ_LATENCY].owner;
        if (m0_rvalid_d) begin
            m0_rdata_d = ssram_dq_in;
        end else begin
            m0_rdata_d = m0_rdata_q;
        end
        if (m1_rvalid_d) begin
            m1_rdata_d = ssram_dq_in;
        end else begin
            m1_rdata_d = m1_rdata_q;
        end
    end

    // State registers; reset drops in-flight reads and idles the pins at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            dq_out_q    <= '0;
            be_n_q      <= IDLE_BE_N;
            adsc_n_q    <= IDLE_ADSC_N;
            we_n_q      <= IDLE_WE_N;
            oe_n_q      <= IDLE_OE_N;
            dq_oe_q     <= IDLE_DQ_OE;
            tag_q       <= {(READ_LATENCY+1){TAG_EMPTY}};
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            be_n_q      <= be_n_d;
            adsc_n_q    <= adsc_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_oe_q     <= dq_oe_d;
            tag_q       <= tag_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign ssram_addr   = addr_q;
    assign ssram_dq_out = dq_out_q;
    assign ssram_be_n   = be_n_q;
    assign ssram_adsc_n = adsc_n_q;
    assign ssram_we_n   = we_n_q;
    assign ssram_oe_n   = oe_n_q;
    assign ssram_dq_oe  = dq_oe_q;
    assign m0_rvalid    = m0_rvalid_q;
    assign m1_rvalid    = m1_rvalid_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;

endmodule

// File: tb/tb_ssram_arbiter.sv
// Bench for ssram_arbiter: SSRAM pin model plus a transaction-level reference
// model of arbitration, write hazard and read return timing.
module tb_ssram_arbiter;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [19:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_rvalid, m1_ack, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [19:0] ssram_addr;
    logic [3:0]  ssram_be_n;
    logic        ssram_adsc_n, ssram_we_n, ssram_oe_n, ssram_dq_oe;
    logic [31:0] ssram_dq_out, ssram_dq_in;

    ssram_arbiter #(.ADDR_W(20), .DATA_W(32), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ssram_addr(ssram_addr), .ssram_be_n(ssram_be_n), .ssram_adsc_n(ssram_adsc_n),
        .ssram_we_n(ssram_we_n), .ssram_oe_n(ssram_oe_n), .ssram_dq_out(ssram_dq_out),
        .ssram_dq_oe(ssram_dq_oe), .ssram_dq_in(ssram_dq_in)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    // Pipelined SSRAM: command seen on the pins, data on dq_in RL cycles later
    logic [31:0] mem [256];
    logic [31:0] p1;
    always @(posedge clk) begin
        if (!ssram_adsc_n && !ssram_we_n)
            mem[ssram_addr[7:0]] <= merge(mem[ssram_addr[7:0]], ssram_dq_out, ~ssram_be_n);
        if (!ssram_adsc_n && ssram_we_n) p1 <= mem[ssram_addr[7:0]];
        else                             p1 <= 32'hBAD0_BAD0;
        ssram_dq_in <= p1;
    end

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } ret_t;

    int checks = 0, errors = 0, cyc = 0;
    bit last_m1 = 1'b1, prev_g = 1'b0;
    int last_rd = -100;
    ret_t rq[$];
    logic [31:0] shadow [256];
    int dut_ack0 = -1, dut_ack1 = -1, rv_cyc1 = -1;
    logic [31:0] seen0 = 32'h0, seen1 = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance the model
    task automatic tick();
        bit busy, win, wwe, g, e0, e1, drop0, drop1;
        logic [19:0] wa;
        logic [31:0] wd, ed;
        logic [3:0]  wb;
        int d;
        @(negedge clk);
        d    = cyc - last_rd;
        busy = (d >= 1) && (d <= RL + 1);
        if (m0_req && m1_req) win = ~last_m1;
        else                  win = ~m0_req;
        wwe = win ? m1_we : m0_we;
        wa  = win ? m1_addr : m0_addr;
        wd  = win ? m1_wdata : m0_wdata;
        wb  = win ? m1_be : m0_be;
        g   = (m0_req || m1_req) && !(wwe && busy);
        chk("ack0", 32'(m0_ack), 32'(g && !win));
        chk("ack1", 32'(m1_ack), 32'(g && win));
        if (m0_ack === 1'b1) dut_ack0 = cyc;
        if (m1_ack === 1'b1) dut_ack1 = cyc;
        e0 = 1'b0; e1 = 1'b0; ed = 32'h0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e0 = !rq[0].port; e1 = rq[0].port; ed = rq[0].data;
            rq.delete(0);
        end
        chk("rvalid0", 32'(m0_rvalid), 32'(e0));
        chk("rvalid1", 32'(m1_rvalid), 32'(e1));
        if (e0) chk("rdata0", m0_rdata, ed);
        if (e1) chk("rdata1", m1_rdata, ed);
        if (m0_rvalid === 1'b1) seen0 = m0_rdata;
        if (m1_rvalid === 1'b1) begin seen1 = m1_rdata; rv_cyc1 = cyc; end
        chk("adsc_n", 32'(ssram_adsc_n), 32'(!prev_g));
        chk("oe_excl", 32'(!ssram_oe_n && ssram_dq_oe), 32'h0);
        prev_g = g; drop0 = 1'b0; drop1 = 1'b0;
        if (g) begin
            last_m1 = win;
            if (wwe) shadow[wa[7:0]] = merge(shadow[wa[7:0]], wd, wb);
            else begin
                last_rd = cyc;
                rq.push_back('{due: cyc + RL + 2, port: win, data: shadow[wa[7:0]]});
            end
            if (win) drop1 = 1'b1; else drop0 = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (drop0) m0_req = 1'b0;
        if (drop1) m1_req = 1'b0;
    endtask

    task automatic set0(input logic we, input logic [19:0] a, input logic [31:0] dt, input logic [3:0] be);
        m0_we = we; m0_addr = a; m0_wdata = dt; m0_be = be; m0_req = 1'b1;
    endtask

    task automatic set1(input logic we, input logic [19:0] a, input logic [31:0] dt, input logic [3:0] be);
        m1_we = we; m1_addr = a; m1_wdata = dt; m1_be = be; m1_req = 1'b1;
    endtask

    initial begin
        int t, k;
        for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; shadow[i] = 32'h0; end
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_adsc", 32'(ssram_adsc_n), 32'h1);
        chk("rst_we", 32'(ssram_we_n), 32'h1);
        chk("rst_oe", 32'(ssram_oe_n), 32'h1);
        chk("rst_be", 32'(ssram_be_n), 32'hF);
        chk("rst_addr", 32'(ssram_addr), 32'h0);
        chk("rst_dqout", ssram_dq_out, 32'h0);
        chk("rst_dqoe", 32'(ssram_dq_oe), 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        reset = 1'b0;

        // Write then read back through the other port
        set0(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF);
        tick();
        chk("w_adsc", 32'(ssram_adsc_n), 32'h0);
        chk("w_we", 32'(ssram_we_n), 32'h0);
        chk("w_dqoe", 32'(ssram_dq_oe), 32'h1);
        chk("w_oe", 32'(ssram_oe_n), 32'h1);
        chk("w_addr", 32'(ssram_addr), 32'h10);
        chk("w_dq", ssram_dq_out, 32'hDEADBEEF);
        chk("w_be", 32'(ssram_be_n), 32'h0);
        set1(1'b0, 20'h00010, 32'h0, 4'hF);
        tick();
        t = dut_ack1;
        repeat (6) tick();
        chk("raw_lat", 32'(rv_cyc1), 32'(t + 4));
        chk("raw_data", seen1, 32'hDEADBEEF);

        // Both ports streaming reads
        for (int i = 0; i < 8; i++) begin
            if (!m0_req) set0(1'b0, 20'(32'h40 + i), 32'h0, 4'hF);
            if (!m1_req) set1(1'b0, 20'(32'h80 + i), 32'h0, 4'hF);
            tick();
        end
        m0_req = 0; m1_req = 0;
        repeat (6) tick();

        // Write behind an in-flight read waits for the tag pipeline to drain
        set1(1'b0, 20'h00020, 32'h0, 4'hF);
        tick();
        t = dut_ack1;
        set0(1'b1, 20'h00021, 32'hCAFEF00D, 4'hF);
        k = 0;
        while (m0_req && k < 12) begin tick(); k++; end
        chk("hazard_ack", 32'(dut_ack0), 32'(t + 4));
        m0_req = 0;
        repeat (4) tick();

        // Partial byte-enable write
        set0(1'b1, 20'h00030, 32'hFFFFFFFF, 4'hF);
        tick();
        set0(1'b1, 20'h00030, 32'h11223344, 4'b0101);
        tick();
        chk("be_pins", 32'(ssram_be_n), 32'hA);
        set0(1'b0, 20'h00030, 32'h0, 4'hF);
        tick();
        repeat (6) tick();
        chk("be_rdata", seen0, 32'hFF22FF44);

        // Reset one cycle after a read ack
        set0(1'b0, 20'h00030, 32'h0, 4'hF);
        tick();
        seen0 = 32'h0;
        #2 reset = 1'b1;
        #1;
        chk("arst_adsc", 32'(ssram_adsc_n), 32'h1);
        chk("arst_oe", 32'(ssram_oe_n), 32'h1);
        chk("arst_dqoe", 32'(ssram_dq_oe), 32'h0);
        chk("arst_be", 32'(ssram_be_n), 32'hF);
        rq.delete(); last_m1 = 1'b1; last_rd = -100; prev_g = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) tick();
        chk("arst_norv", seen0, 32'h0);
        set0(1'b0, 20'h00030, 32'h0, 4'hF);
        set1(1'b0, 20'h00031, 32'h0, 4'hF);
        tick();
        chk("post_rst_first", 32'(dut_ack0), 32'(cyc - 1));
        tick();
        repeat (6) tick();
        chk("post_rst_data", seen0, 32'hFF22FF44);

        // Randomized traffic on a small address window
        for (int i = 0; i < 400; i++) begin
            if (!m0_req && $urandom_range(0, 2) != 0)
                set0(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), $urandom, 4'($urandom));
            if (!m1_req && $urandom_range(0, 2) != 0)
                set1(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), $urandom, 4'($urandom));
            if (m0_req && $urandom_range(0, 15) == 0) m0_req = 1'b0;
            if (m1_req && $urandom_range(0, 15) == 0) m1_req = 1'b0;
            tick();
        end
        m0_req = 0; m1_req = 0;
        repeat (8) tick();
        chk("drained", 32'(rq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssram_arbiter.md
Name: ssram_arbiter

Overview:
- Two-port arbiter and sequencer that shares the board's single pipelined synchronous SSRAM (ADSC-initiated, single-word accesses) between two on-chip requesters, for example a frame-capture writer and a display reader.
- Sits between the requesters and the top-level SSRAM pins (FS_ADDR[21:2], FS_DQ, SSRAM_BE, SSRAM_OE_N, SSRAM_WE_N, SSRAM_ADSC_N).
- The top level owns the FS_DQ tristate, built from ssram_dq_out, ssram_dq_oe and ssram_dq_in.

Parameters:
- ADDR_W, 20, word address width (FS_ADDR[21:2]).
- DATA_W, 32, data width.
- READ_LATENCY, 2, cycles from the command on the pins until read data is valid on ssram_dq_in.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  access request; held with its fields until ack.
- m0_we, m1_we  in  1  1=write, 0=read.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_be, m1_be  in  4  byte enables, active-high.
- m0_ack, m1_ack  out  1  combinational; request accepted this cycle.
- m0_rvalid, m1_rvalid  out  1  one-cycle read-data strobe.
- m0_rdata, m1_rdata  out  DATA_W  read data, valid with rvalid.
- ssram_addr  out  ADDR_W  registered address.
- ssram_be_n  out  4  registered byte enables, active-low.
- ssram_adsc_n  out  1  registered address strobe, active-low.
- ssram_we_n  out  1  registered write enable, active-low.
- ssram_oe_n  out  1  registered output enable, active-low.
- ssram_dq_out  out  DATA_W  registered write data.
- ssram_dq_oe  out  1  registered; 1 = FPGA drives FS_DQ.
- ssram_dq_in  in  DATA_W  FS_DQ input.

Behaviour:
- Reset values:
  - ssram_adsc_n=1, ssram_we_n=1, ssram_oe_n=1, ssram_be_n=4'hF.
  - ssram_addr=0, ssram_dq_out=0, ssram_dq_oe=0.
  - all acks, rvalids and rdata=0.
  - priority pointer favours m0.
  - read-tag pipeline cleared.
- Arbitration:
  - Round-robin, one command per cycle.
  - If only one port requests, it wins.
  - If both request, the port not granted most recently wins. The pointer updates only on an actual grant.
- Write hazard: a write is granted only if no read is in flight (all READ_LATENCY+1 tag stages empty).
  - If the winner is a blocked write, no grant is issued that cycle. The other port is not bypassed, which keeps ordering and fairness.
  - The write is granted on the first cycle the pipeline is empty.
- Grant in cycle T:
  - mX_ack=1 during T.
  - At the edge ending T, the pins register the command: adsc_n=0, addr, be_n=~be, we_n=~we.
  - For writes, also dq_out=wdata, dq_oe=1 and oe_n=1.
  - With no grant, adsc_n=1, we_n=1, dq_oe=0 and be_n=4'hF; addr and dq_out hold.
- Read return:
  - The pins show the command in cycle T+1.
  - ssram_dq_in is sampled at the end of cycle T+1+READ_LATENCY.
  - The owner sees mX_rvalid=1 with rdata in cycle T+2+READ_LATENCY (T+4 at default).
  - Reads from either port may issue back-to-back. The tag shift register (valid bit + owner bit per stage) routes each return, so returns never reorder.
- Output enable: oe_n=0 from the read command cycle until its data-sample cycle, held for back-to-back reads; otherwise oe_n=1. oe_n and dq_oe are never both active.
- Read after write may issue the next cycle; no turnaround gap is needed.
- Simultaneous request + in-flight return on the same port: independent. ack and rvalid may both be high in the same cycle.
- Reset mid-operation: all in-flight reads are dropped (no rvalid after reset) and the pins return to idle immediately (asynchronous).
- Deasserting req without ack is allowed; nothing is issued.

Decomposition:
- Shared include ssram_defs.v, holding:
  - localparams for the idle pin levels;
  - the tag field layout (valid, owner);
  - the default READ_LATENCY.
- One natural sub-module: ssram_rr_arbiter.
  - Inputs: 2-way requests and per-request "eligible" (write-blocked) flags.
  - Outputs: one-hot grant and the last-winner register.
- The top of ssram_arbiter holds the pin registers, tag pipeline and return demux.

Test Plan:
- m0 writes addr 0x00010 data 0xDEADBEEF be 4'hF, then m1 reads 0x00010.
  - m0_ack in the grant cycle; pins show adsc_n=0, we_n=0, dq_oe=1 next cycle.
  - m1_rvalid 4 cycles after m1_ack with rdata 0xDEADBEEF.
- Both ports continuously request reads at distinct addresses for 8 cycles.
  - Acks alternate m0,m1,m0,…; one adsc_n pulse per cycle; each rvalid lands on the correct port in issue order.
- m1 reads 0x00020 at cycle T, m0 write requested at T+1.
  - m0_ack is withheld until the tag pipeline is empty: first ack at T+4, no earlier.
  - oe_n and dq_oe are never simultaneously active.
- Byte-enable write: be 4'b0101 data 0x11223344 over 0xFFFFFFFF, then read.
  - ssram_be_n=4'b1010 on the pins; read returns 0xFF22FF44 (SSRAM model).
- Assert reset one cycle after a read ack.
  - Pins go idle asynchronously; no rvalid afterward.
  - A post-reset read of the same address is acknowledged normally, with m0 preferred first.
